// File: rtl/uart_alu_controller.sv
// -----------------------------------------------------------------------------
// uart_alu_controller
// Sequences one UART-driven ALU transaction: receive operand A, operand B and
// an opcode, validate the opcode, present the operands to the ALU for one
// execute cycle, capture the result and hand it to the UART transmitter.
// Protocol problems are reported as a one-cycle o_error pulse with a held code.
//
// Optional feature macro: UART_ALU_TIMEOUT_EN
//   defined   -> idle timeout in WAIT_B / WAIT_OP / WAIT_TX, error code 01
//   undefined -> no timeout counter, those states wait indefinitely
//
// Ports
//   i_clock       clock, rising edge
//   i_reset       synchronous active-high reset
//   i_rx_data     received byte, qualified by i_rx_done
//   i_rx_done     one-cycle pulse per received byte
//   i_alu_result  combinational ALU result for o_dato_A / o_dato_B / o_OP
//   i_tx_done     one-cycle pulse, transmitter finished the byte
//   o_dato_A      operand A (registered)
//   o_dato_B      operand B (registered)
//   o_OP          opcode (registered)
//   o_tx_data     result byte for the transmitter (registered)
//   o_tx_start    one-cycle transmit start pulse
//   o_busy        high in every state except WAIT_A
//   o_error       one-cycle error pulse
//   o_err_code    01 timeout, 10 illegal opcode, 11 overrun; held between errors
// -----------------------------------------------------------------------------
module uart_alu_controller #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_dato_A,
    output logic [NB_DATA-1:0] o_dato_B,
    output logic [NB_OP-1:0]   o_OP,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_error,
    output logic [1:0]         o_err_code
);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] dato_a_q, dato_a_d;
    logic [NB_DATA-1:0] dato_b_q, dato_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               accept_c;
    logic               expired_c;
    logic               waiting_c;

    // Opcode whitelist (ADD SUB AND OR XOR NOR SRA SRL)
    function automatic logic is_legal_op(input logic [NB_OP-1:0] op);
        logic legal;
        case (op)
            NB_OP'(6'b100000),
            NB_OP'(6'b100010),
            NB_OP'(6'b100100),
            NB_OP'(6'b100101),
            NB_OP'(6'b100110),
            NB_OP'(6'b100111),
            NB_OP'(6'b000011),
            NB_OP'(6'b000010): legal = 1'b1;
            default:           legal = 1'b0;
        endcase
        return legal;
    endfunction

    // States supervised by the idle timeout
    assign waiting_c = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP) ||
                       (state_q == ST_WAIT_TX);

`ifdef UART_ALU_TIMEOUT_EN
    localparam int unsigned NB_CNT = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [NB_CNT-1:0] cnt_q, cnt_d;

    // Expiry fires in the cycle the count would step to TIMEOUT_CYCLES-1,
    // so the registered error lands TIMEOUT_CYCLES cycles after the last byte.
    assign expired_c = waiting_c && (cnt_q == NB_CNT'(TIMEOUT_CYCLES - 2));

    // Idle counter: restarts on any state change or accepted byte
    always_comb begin
        cnt_d = '0;
        if (waiting_c && (state_d == state_q) && !accept_c) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expired_c = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_WAIT_A;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            dato_a_q   <= dato_a_d;
            dato_b_q   <= dato_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state, datapath loads and error detection
    always_comb begin
        state_d    = state_q;
        dato_a_d   = dato_a_q;
        dato_b_d   = dato_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        error_d    = 1'b0;
        err_code_d = err_code_q;
        accept_c   = 1'b0;

        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    dato_a_d = i_rx_data;
                    accept_c = 1'b1;
                    state_d  = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    dato_b_d = i_rx_data;
                    accept_c = 1'b1;
                    state_d  = ST_WAIT_OP;
                end else if (expired_c) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    accept_c = 1'b1;
                    if (is_legal_op(i_rx_data[NB_OP-1:0])) begin
                        op_d    = i_rx_data[NB_OP-1:0];
                        state_d = ST_EXEC;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                        state_d    = ST_WAIT_A;
                    end
                end else if (expired_c) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_WAIT_A;
                end
            end
            ST_EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end else if (expired_c) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_WAIT_A;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase

        // Byte arriving while a result is in flight is dropped
        if (i_rx_done && !error_d &&
            ((state_q == ST_EXEC) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX))) begin
            error_d    = 1'b1;
            err_code_d = ERR_OVERRUN;
        end
    end

    // Moore outputs, registered from the upcoming state
    always_comb begin
        tx_start_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_WAIT_A);
    end

    assign o_dato_A   = dato_a_q;
    assign o_dato_B   = dato_b_q;
    assign o_OP       = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_error    = error_q;
    assign o_err_code = err_code_q;

endmodule

// File: tb/tb_uart_alu_controller.sv
// -----------------------------------------------------------------------------
// Bench for uart_alu_controller. Stimulus pushes expected transmit starts and
// error pulses into a scoreboard queue; a negedge monitor pops and compares
// every o_tx_start / o_error the DUT produces (value and cycle).
// -----------------------------------------------------------------------------
module tb_uart_alu_controller;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OP   = 6;
    localparam int unsigned TO_CYC  = 8;

    logic               clk;
    logic               rst;
    logic [NB_DATA-1:0] rx_data;
    logic               rx_done;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_done;
    logic [NB_DATA-1:0] dato_a;
    logic [NB_DATA-1:0] dato_b;
    logic [NB_OP-1:0]   op;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               busy;
    logic               error;
    logic [1:0]         err_code;

    uart_alu_controller #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_dato_A     (dato_a),
        .o_dato_B     (dato_b),
        .o_OP         (op),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy),
        .o_error      (error),
        .o_err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU driven by the DUT operand registers
    always_comb begin
        case (op)
            6'b100000: alu_result = dato_a + dato_b;
            6'b100010: alu_result = dato_a - dato_b;
            6'b100100: alu_result = dato_a & dato_b;
            6'b100101: alu_result = dato_a | dato_b;
            6'b100110: alu_result = dato_a ^ dato_b;
            6'b100111: alu_result = ~(dato_a | dato_b);
            6'b000011: alu_result = 8'($signed(dato_a) >>> dato_b);
            6'b000010: alu_result = dato_a >> dato_b;
            default:   alu_result = 8'h00;
        endcase
    end

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] opc;
        logic [7:0] data;
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (tx_start || error)) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: tx_start=%0b error=%0b code=%0b cyc=%0d",
                         tx_start, error, err_code, ncyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("event_kind", 32'(error), 32'(e.is_err));
                check("event_cycle", 32'(ncyc), 32'(e.cyc));
                if (e.is_err) begin
                    check("err_code", 32'(err_code), 32'(e.code));
                end else begin
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("dato_A", 32'(dato_a), 32'(e.a));
                    check("dato_B", 32'(dato_b), 32'(e.b));
                    check("OP", 32'(op), 32'(e.opc));
                end
            end
        end
    end

    task automatic push_tx(input logic [7:0] a, input logic [7:0] b, input logic [5:0] o,
                           input logic [7:0] d, input int cyc);
        exp_t e;
        e.is_err = 1'b0; e.a = a; e.b = b; e.opc = o; e.data = d; e.code = 2'b00; e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code, input int cyc);
        exp_t e;
        e.is_err = 1'b1; e.a = '0; e.b = '0; e.opc = '0; e.data = '0; e.code = code; e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    // One byte pulse; returns the cycle index in which rx_done was high
    task automatic send_byte(input logic [7:0] d, output int k);
        @(posedge clk); #1;
        rx_data = d;
        rx_done = 1'b1;
        k = ncyc;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    // Three bytes on consecutive cycles; returns the opcode cycle
    task automatic send_burst(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                              output int k);
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = a;
        @(posedge clk); #1;
        rx_data = b;
        @(posedge clk); #1;
        rx_data = o;
        k = ncyc;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    // Wait for tx_start, optionally inject an overrun byte, then pulse tx_done
    // five cycles after start and confirm the return to idle.
    task automatic finish_tx(input bit overrun, input logic [7:0] exp_data);
        bit seen = 1'b0;
        int k;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        check("tx_start_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        if (overrun) begin
            @(posedge clk); #1;
            rx_data = 8'h77;
            rx_done = 1'b1;
            k = ncyc;
            push_err(2'b11, k + 1);
            @(posedge clk); #1;
            rx_done = 1'b0;
            @(negedge clk);
            check("tx_data_after_overrun", 32'(tx_data), 32'(exp_data));
            check("busy_after_overrun", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end else begin
            repeat (3) @(posedge clk);
            #1;
        end
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(negedge clk);
        check("busy_idle_after_tx", 32'(busy), 32'd0);
    endtask

    task automatic transaction(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                               input logic [7:0] d, input bit burst);
        int k;
        if (burst) begin
            send_burst(a, b, o, k);
        end else begin
            send_byte(a, k);
            send_byte(b, k);
            send_byte(o, k);
        end
        push_tx(a, b, o[5:0], d, k + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  busy_drop;

        rst     = 1'b1;
        rx_data = '0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dato_A", 32'(dato_a), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;

        // AND: F0 & 0F = 00
        transaction(8'hF0, 8'h0F, 8'h24, 8'h00, 1'b0);
        finish_tx(1'b0, 8'h00);

        // ADD then SUB, zero-gap byte pulses, back to back
        transaction(8'h05, 8'h03, 8'h20, 8'h08, 1'b1);
        finish_tx(1'b0, 8'h08);
        transaction(8'h05, 8'h03, 8'h22, 8'h02, 1'b1);
        finish_tx(1'b0, 8'h02);

        // Illegal opcode 3F: error 10, opcode register untouched
        send_byte(8'h01, k);
        send_byte(8'h02, k);
        send_byte(8'h3F, k);
        push_err(2'b10, k + 1);
        repeat (2) @(negedge clk);
        check("busy_after_illegal", 32'(busy), 32'd0);
        check("op_after_illegal", 32'(op), 32'h22);
        transaction(8'hF0, 8'h0F, 8'h24, 8'h00, 1'b0);
        finish_tx(1'b0, 8'h00);

        // Idle after the first byte
        send_byte(8'hAA, k);
`ifdef UART_ALU_TIMEOUT_EN
        push_err(2'b01, k + 8);
        repeat (12) @(negedge clk);
        check("busy_after_timeout", 32'(busy), 32'd0);
        check("dato_A_after_timeout", 32'(dato_a), 32'hAA);
`else
        busy_drop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) busy_drop = 1'b1;
        end
        check("busy_held_no_timeout", 32'(busy_drop), 32'd0);
        send_byte(8'h55, k);
        send_byte(8'h20, k);
        push_tx(8'hAA, 8'h55, 6'h20, 8'hFF, k + 2);
        finish_tx(1'b0, 8'hFF);
`endif

        // XOR 0C ^ 0A = 06, overrun byte during WAIT_TX
        transaction(8'h0C, 8'h0A, 8'h26, 8'h06, 1'b0);
        finish_tx(1'b1, 8'h06);

        // Reset while waiting for the opcode
        send_byte(8'h11, k);
        send_byte(8'h22, k);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst2_dato_A", 32'(dato_a), 32'd0);
        check("rst2_dato_B", 32'(dato_b), 32'd0);
        check("rst2_OP", 32'(op), 32'd0);
        check("rst2_tx_data", 32'(tx_data), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_err_code", 32'(err_code), 32'd0);

        // Fresh transactions: SRA 81>>>2 = E0, SRL 81>>2 = 20
        transaction(8'h81, 8'h02, 8'h03, 8'hE0, 1'b0);
        finish_tx(1'b0, 8'hE0);
        transaction(8'h81, 8'h02, 8'hC2, 8'h20, 1'b1);
        finish_tx(1'b0, 8'h20);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
